// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Purpose:
//   Initiator side of an external 4-bit combinational ALU. Accepts a wide
//   command (NIBBLES x 4 bits) on a valid/ready request channel. Runs it one
//   nibble at a time through the ALU, least-significant nibble first. The
//   ALU has no carry input, so a carry or borrow into a nibble is applied by
//   an extra FIX pass (+1 for ADD, -1 for SUB) on that nibble. The wide
//   result is returned on a valid/ready response channel.
//
// Optional feature:
//   ALU_SEQ_OVF_EN - when defined, adds rsp_ovf, which flags two's-complement
//   overflow of ADD/SUB on bit DW-1.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready   request handshake; cmd_op 00 ADD, 01 SUB, 10 AND, 11 OR
//   cmd_a, cmd_b      DW-bit operands
//   alu_a/b/op        nibble operands and op_code driven to the ALU
//   alu_result/carry  combinational ALU answer (SUB carry: 1 = no borrow)
//   rsp_valid/ready   response handshake
//   rsp_data          DW-bit result
//   rsp_carry         final carry / no-borrow (0 for AND/OR)
//   rsp_zero          rsp_data == 0
//   rsp_ovf           (ALU_SEQ_OVF_EN only) signed overflow
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int NIBBLES = 2,
  localparam int DW = 4 * NIBBLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [1:0]    alu_op,
  input  logic [3:0]    alu_result,
  input  logic          alu_carry,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_carry,
  output logic          rsp_zero
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic          rsp_ovf
`endif
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAIN, ST_FIX, ST_RESP} state_t;

  state_t        r_state;
  logic [1:0]    r_op;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [1:0]    r_idx;
  logic          r_k;      // chain bit: ADD carry, SUB no-borrow
  logic          r_cmain;  // carry of the MAIN pass awaiting its FIX pass
  logic [3:0]    r_data_nib [4];

  state_t        w_state_next;
  logic [1:0]    w_idx_next;
  logic          w_k_next;
  logic          w_cmain_next;
  logic          w_wr_en;
  logic          w_is_arith;
  logic          w_fix_req;
  logic          w_in_resp;
  logic [3:0]    w_a_nib [4];
  logic [3:0]    w_b_nib [4];
  logic [DW-1:0] w_data_flat;

  // Nibble views padded to four entries so a 2-bit index is always in range.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    if (gi < NIBBLES) begin : g_used
      assign w_a_nib[gi]            = r_a[gi*4 +: 4];
      assign w_b_nib[gi]            = r_b[gi*4 +: 4];
      assign w_data_flat[gi*4 +: 4] = r_data_nib[gi];
    end else begin : g_pad
      assign w_a_nib[gi] = 4'h0;
      assign w_b_nib[gi] = 4'h0;
    end
  end

  assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  // A pending carry (ADD) or pending borrow (SUB) into the current nibble.
  assign w_fix_req  = (r_op == OP_ADD) ? r_k : ~r_k;
  assign w_in_resp  = (r_state == ST_RESP);

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = w_in_resp;
  assign rsp_data  = w_in_resp ? w_data_flat : '0;
  assign rsp_carry = w_in_resp && w_is_arith && r_k;
  assign rsp_zero  = w_in_resp && (w_data_flat == '0);

`ifdef ALU_SEQ_OVF_EN
  logic w_sa, w_sb, w_sr;
  assign w_sa = r_a[DW-1];
  assign w_sb = r_b[DW-1];
  assign w_sr = w_data_flat[DW-1];
  assign rsp_ovf = w_in_resp &&
                   (((r_op == OP_ADD) && (w_sa == w_sb) && (w_sr != w_sa)) ||
                    ((r_op == OP_SUB) && (w_sa != w_sb) && (w_sr != w_sa)));
`endif

  // Next-state, chain bookkeeping and ALU drive.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_k_next     = r_k;
    w_cmain_next = r_cmain;
    w_wr_en      = 1'b0;
    alu_a        = 4'h0;
    alu_b        = 4'h0;
    alu_op       = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_next = ST_MAIN;
        end
      end
      ST_MAIN: begin
        alu_a   = w_a_nib[r_idx];
        alu_b   = w_b_nib[r_idx];
        alu_op  = r_op;
        w_wr_en = 1'b1;
        if (w_is_arith && (r_idx != 2'd0) && w_fix_req) begin
          w_cmain_next = alu_carry;
          w_state_next = ST_FIX;
        end else begin
          if (w_is_arith) begin
            w_k_next = alu_carry;
          end
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_RESP;
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end
      end
      ST_FIX: begin
        // ADD op adds 1, SUB op subtracts 1 from the stored nibble.
        alu_a   = r_data_nib[r_idx];
        alu_b   = 4'h1;
        alu_op  = r_op;
        w_wr_en = 1'b1;
        w_k_next = (r_op == OP_ADD) ? (r_cmain | alu_carry) : (r_cmain & alu_carry);
        if (r_idx == LAST_IDX) begin
          w_state_next = ST_RESP;
        end else begin
          w_idx_next = r_idx + 2'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= 2'd0;
      r_k     <= 1'b0;
      r_cmain <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        r_data_nib[n] <= 4'h0;
      end
    end else begin
      r_state <= w_state_next;
      r_cmain <= w_cmain_next;
      if (r_state == ST_IDLE) begin
        if (cmd_valid) begin
          r_op  <= cmd_op;
          r_a   <= cmd_a;
          r_b   <= cmd_b;
          r_idx <= 2'd0;
          r_k   <= (cmd_op == OP_SUB);
        end
      end else begin
        r_idx <= w_idx_next;
        r_k   <= w_k_next;
      end
      if (w_wr_en) begin
        r_data_nib[r_idx] <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Purpose:
//   Self-checking bench for alu_op_sequencer with NIBBLES=2. Provides the
//   external 4-bit ALU as a combinational model and predicts wide results,
//   carry, zero, overflow and latency directly from whole-word arithmetic.
//   Define ALU_SEQ_OVF_EN for both files to exercise rsp_ovf.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int N  = 2;
  localparam int DW = 4 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [1:0]    alu_op;
  logic [3:0]    alu_result;
  logic          alu_carry;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_carry;
  logic          rsp_zero;
`ifdef ALU_SEQ_OVF_EN
  logic          rsp_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  alu_op_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`ifdef ALU_SEQ_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  // External 4-bit ALU.
  always_comb begin
    alu_result = 4'h0;
    alu_carry  = 1'b0;
    case (alu_op)
      2'b00: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a >= alu_b);
      end
      2'b10: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: result, final carry/no-borrow, overflow, and the
  // number of upper nibbles that receive a carry (ADD) or borrow (SUB).
  function automatic void ref_model(input logic [1:0] op, input int a, input int b,
                                    output int d, output int c, output int ovf,
                                    output int fixes);
    int m, p, sa, sb, sr;
    m = 1 << DW;
    d = 0; c = 0; ovf = 0; fixes = 0;
    case (op)
      2'b00: begin
        d = (a + b) % m;
        c = ((a + b) >= m) ? 1 : 0;
        for (int i = 1; i < N; i++) begin
          p = 1 << (4 * i);
          if (((a % p) + (b % p)) >= p) fixes++;
        end
      end
      2'b01: begin
        d = (a - b + m) % m;
        c = (a >= b) ? 1 : 0;
        for (int i = 1; i < N; i++) begin
          p = 1 << (4 * i);
          if ((a % p) < (b % p)) fixes++;
        end
      end
      2'b10: d = a & b;
      default: d = a | b;
    endcase
    sa = (a >> (DW - 1)) & 1;
    sb = (b >> (DW - 1)) & 1;
    sr = (d >> (DW - 1)) & 1;
    if (op == 2'b00) ovf = ((sa == sb) && (sr != sa)) ? 1 : 0;
    if (op == 2'b01) ovf = ((sa != sb) && (sr != sa)) ? 1 : 0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data, 0);
    check({tag, "_rsp_carry"}, rsp_carry, 0);
    check({tag, "_rsp_zero"},  rsp_zero, 0);
    check({tag, "_alu_a"},     alu_a, 0);
    check({tag, "_alu_b"},     alu_b, 0);
    check({tag, "_alu_op"},    alu_op, 0);
`ifdef ALU_SEQ_OVF_EN
    check({tag, "_rsp_ovf"},   rsp_ovf, 0);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic run_cmd(input logic [1:0] op, input int a, input int b, input int hold);
    int d, c, ovf, fixes, edges;
    ref_model(op, a, b, d, c, ovf, fixes);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = DW'(a);
    cmd_b     = DW'(b);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    // Garbage on the command port while busy must be ignored.
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom);
    cmd_a     = DW'($urandom);
    cmd_b     = DW'($urandom);
    while (rsp_valid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("latency", edges, N + fixes + 1);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, d);
      check("rsp_carry", rsp_carry, c);
      check("rsp_zero", rsp_zero, (d == 0) ? 1 : 0);
      check("cmd_ready_busy", cmd_ready, 0);
`ifdef ALU_SEQ_OVF_EN
      check("rsp_ovf", rsp_ovf, ovf);
`endif
    end
    check("alu_a_resp", alu_a, 0);
    check("alu_op_resp", alu_op, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("rsp_valid_release", rsp_valid, 0);
    check("cmd_ready_release", cmd_ready, 1);
    $display("txn op=%0d a=%0h b=%0h data=%0h exp=%0h carry=%0b lat=%0d hold=%0d",
             op, a, b, rsp_data, d, c, edges, hold);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    run_cmd(2'b00, 'h3C, 'h0F, 0);
    run_cmd(2'b00, 'hFF, 'h01, 0);
    run_cmd(2'b01, 'h10, 'h01, 0);
    run_cmd(2'b01, 'h00, 'h01, 0);
    run_cmd(2'b01, 'h80, 'h01, 0);
    run_cmd(2'b10, 'hF0, 'h3C, 0);
    run_cmd(2'b11, 'h00, 'h00, 0);
    // Backpressure, then a back-to-back command.
    run_cmd(2'b00, 'h12, 'h34, 5);
    run_cmd(2'b01, 'h55, 'h23, 0);

    // Reset during the FIX pass of 0xFF + 0x01.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'hFF; cmd_b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("fix_alu_b", alu_b, 1);
    check("fix_alu_a", alu_a, 'hF);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(2'b00, 'h01, 'h01, 0);

    // Randomized commands.
    repeat (40) begin
      run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, (1 << DW) - 1)),
              int'($urandom_range(0, (1 << DW) - 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
